// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, funct3 encodings, memory-stage FSM
// states, fault causes and the access legality / byte-lane helpers.
package rv32i_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_funct3_e;

  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010
  } store_funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_MISALIGN = 2'd1,
    CAUSE_ILLEGAL  = 2'd2,
    CAUSE_TIMEOUT  = 2'd3
  } fault_cause_e;

  // Classify an access before any bus cycle: illegal funct3 wins over misalignment.
  function automatic fault_cause_e access_cause(input logic       is_load,
                                                input logic [2:0] f3,
                                                input logic [1:0] lo);
    logic legal;
    if (is_load) begin
      legal = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
              (f3 == F3_LBU) || (f3 == F3_LHU);
    end else begin
      legal = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    end
    if (!legal) begin
      return CAUSE_ILLEGAL;
    end else if ((f3[1:0] == 2'b01) && lo[0]) begin
      return CAUSE_MISALIGN;
    end else if ((f3[1:0] == 2'b10) && (lo != 2'b00)) begin
      return CAUSE_MISALIGN;
    end else begin
      return CAUSE_NONE;
    end
  endfunction

  // Byte enables for the access size encoded in funct3[1:0].
  function automatic logic [3:0] byte_sel(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] sel;
    case (size)
      2'b00:   sel = 4'b0001 << lo;
      2'b01:   sel = 4'b0011 << {lo[1], 1'b0};
      default: sel = 4'b1111;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load data lane extraction with sign or zero extension for writeback.
module load_extend
  import rv32i_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted_s;

  // Move the addressed lane down to bit 0, then extend according to the load type.
  always_comb begin
    shifted_s = rdata_i >> {addr_lo_i, 3'b000};
    data_o    = 32'h0000_0000;
    case (funct3_i)
      F3_LB:   data_o = {{24{shifted_s[7]}}, shifted_s[7:0]};
      F3_LH:   data_o = {{16{shifted_s[15]}}, shifted_s[15:0]};
      F3_LW:   data_o = shifted_s;
      F3_LBU:  data_o = {24'h00_0000, shifted_s[7:0]};
      F3_LHU:  data_o = {16'h0000, shifted_s[15:0]};
      default: data_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/data_mem_interface.sv
// RV32I memory-access stage: one req/ack bus transaction per load/store,
// stalling the core until the bus answers, aborting on timeout.
module data_mem_interface
  import rv32i_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [31:0] read_address,
  input  logic [31:0] write_address,
  input  logic [31:0] store_data,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_sel,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        fault,
  output logic [1:0]  fault_cause
);

  // Last REQ cycle index before the access is abandoned.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  mem_state_e   state_q, state_d;
  logic [1:0]   addr_lo_q, addr_lo_d;
  logic [2:0]   funct3_q, funct3_d;
  logic         is_load_q, is_load_d;
  logic [15:0]  cnt_q, cnt_d;
  logic [31:0]  bus_addr_q, bus_addr_d;
  logic [31:0]  bus_wdata_q, bus_wdata_d;
  logic [3:0]   bus_sel_q, bus_sel_d;
  logic         bus_we_q, bus_we_d;
  logic [31:0]  load_data_q, load_data_d;
  logic         load_valid_q, load_valid_d;
  logic         fault_q, fault_d;
  fault_cause_e fault_cause_q, fault_cause_d;

  logic         op_load_s;
  logic         mem_op_s;
  logic [31:0]  eff_addr_s;
  fault_cause_e cause_s;
  logic [31:0]  ext_s;

  assign op_load_s  = (opcode == OPC_LOAD);
  assign mem_op_s   = op_load_s || (opcode == OPC_STORE);
  assign eff_addr_s = op_load_s ? read_address : write_address;
  assign cause_s    = access_cause(op_load_s, funct3, eff_addr_s[1:0]);

  load_extend u_load_extend (
    .rdata_i   (bus_rdata),
    .addr_lo_i (addr_lo_q),
    .funct3_i  (funct3_q),
    .data_o    (ext_s)
  );

  // Next-state and datapath decode; result pulses default low so they last one DONE cycle.
  always_comb begin
    state_d       = state_q;
    addr_lo_d     = addr_lo_q;
    funct3_d      = funct3_q;
    is_load_d     = is_load_q;
    cnt_d         = cnt_q;
    bus_addr_d    = bus_addr_q;
    bus_wdata_d   = bus_wdata_q;
    bus_sel_d     = bus_sel_q;
    bus_we_d      = bus_we_q;
    load_data_d   = load_data_q;
    load_valid_d  = 1'b0;
    fault_d       = 1'b0;
    fault_cause_d = CAUSE_NONE;
    case (state_q)
      ST_IDLE: begin
        if (mem_op_s) begin
          addr_lo_d = eff_addr_s[1:0];
          funct3_d  = funct3;
          is_load_d = op_load_s;
          if (cause_s == CAUSE_NONE) begin
            state_d    = ST_REQ;
            cnt_d      = 16'd0;
            bus_addr_d = {eff_addr_s[31:2], 2'b00};
            bus_sel_d  = byte_sel(funct3[1:0], eff_addr_s[1:0]);
            bus_we_d   = ~op_load_s;
            case (funct3[1:0])
              2'b00:   bus_wdata_d = {4{store_data[7:0]}};
              2'b01:   bus_wdata_d = {2{store_data[15:0]}};
              default: bus_wdata_d = store_data;
            endcase
          end else begin
            // Rejected before the bus: straight to DONE with the fault.
            state_d       = ST_DONE;
            fault_d       = 1'b1;
            fault_cause_d = cause_s;
            load_data_d   = 32'h0000_0000;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus_ack) begin
          state_d      = ST_DONE;
          load_data_d  = is_load_q ? ext_s : 32'h0000_0000;
          load_valid_d = is_load_q;
        end else if (cnt_q == CNT_LAST) begin
          state_d       = ST_DONE;
          fault_d       = 1'b1;
          fault_cause_d = CAUSE_TIMEOUT;
          load_data_d   = 32'h0000_0000;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
        if (state_d == ST_DONE) begin
          bus_addr_d  = 32'h0000_0000;
          bus_wdata_d = 32'h0000_0000;
          bus_sel_d   = 4'b0000;
          bus_we_d    = 1'b0;
          cnt_d       = 16'd0;
        end else begin
          bus_we_d = bus_we_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, latched access and registered outputs, all cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      addr_lo_q     <= 2'b00;
      funct3_q      <= 3'b000;
      is_load_q     <= 1'b0;
      cnt_q         <= 16'd0;
      bus_addr_q    <= 32'h0000_0000;
      bus_wdata_q   <= 32'h0000_0000;
      bus_sel_q     <= 4'b0000;
      bus_we_q      <= 1'b0;
      load_data_q   <= 32'h0000_0000;
      load_valid_q  <= 1'b0;
      fault_q       <= 1'b0;
      fault_cause_q <= CAUSE_NONE;
    end else begin
      state_q       <= state_d;
      addr_lo_q     <= addr_lo_d;
      funct3_q      <= funct3_d;
      is_load_q     <= is_load_d;
      cnt_q         <= cnt_d;
      bus_addr_q    <= bus_addr_d;
      bus_wdata_q   <= bus_wdata_d;
      bus_sel_q     <= bus_sel_d;
      bus_we_q      <= bus_we_d;
      load_data_q   <= load_data_d;
      load_valid_q  <= load_valid_d;
      fault_q       <= fault_d;
      fault_cause_q <= fault_cause_d;
    end
  end

  // Stall is raised combinationally in IDLE so the op is frozen from its first cycle.
  assign stall       = ((state_q == ST_IDLE) && mem_op_s && !rst) || (state_q == ST_REQ);
  assign bus_req     = (state_q == ST_REQ);
  assign bus_we      = bus_we_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wdata   = bus_wdata_q;
  assign bus_sel     = bus_sel_q;
  assign load_data   = load_data_q;
  assign load_valid  = load_valid_q;
  assign fault       = fault_q;
  assign fault_cause = fault_cause_q;

endmodule

// File: tb/tb_data_mem_interface.sv
// Scoreboard bench for data_mem_interface: the driver pushes expected bus
// requests, result pulses and stall windows; a monitor pops and compares.
module tb_data_mem_interface;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] read_address, write_address, store_data;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_sel;
  logic        stall, load_valid, fault;
  logic [31:0] load_data;
  logic [1:0]  fault_cause;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] wdata;
    logic        chk_wdata;
    int          len;
  } bus_exp_t;

  typedef struct {
    logic        is_fault;
    logic [1:0]  cause;
    logic [31:0] data;
  } resp_t;

  typedef struct {
    int          len;
    logic [31:0] ld;
  } stall_exp_t;

  bus_exp_t   bus_q[$];
  resp_t      resp_q[$];
  stall_exp_t stall_q[$];

  int          plan_delay = 0;
  logic [31:0] plan_rdata = 32'h0;
  logic        rst_seen = 1'b0;

  data_mem_interface #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
    .read_address(read_address), .write_address(write_address), .store_data(store_data),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_sel(bus_sel), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .stall(stall),
    .load_data(load_data), .load_valid(load_valid), .fault(fault), .fault_cause(fault_cause)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rst_seen <= rst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Bus slave: acks on the planned REQ cycle, throws stray acks while idle.
  initial begin : responder
    int n = 0;
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (bus_req) begin
        bus_ack   = (n == plan_delay);
        bus_rdata = bus_ack ? plan_rdata : $urandom;
        n++;
      end else begin
        n = 0;
        bus_ack   = ($urandom_range(0, 3) == 0);
        bus_rdata = $urandom;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents an event.
  initial begin : monitor
    int         stall_n = 0;
    int         req_n = 0;
    bit         have_cur = 0;
    bus_exp_t   cur;
    resp_t      r;
    stall_exp_t s;
    forever begin
      @(negedge clk);
      if (rst_seen) begin
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_sel", {28'd0, bus_sel}, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_bus_we", {31'd0, bus_we}, 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_pulses", {29'd0, load_valid, fault, |fault_cause}, 32'd0);
      end
      if (bus_req) begin
        if (req_n == 0) begin
          if (bus_q.size() == 0) begin
            flag("unexpected_bus_req");
            have_cur = 0;
          end else begin
            cur = bus_q.pop_front();
            have_cur = 1;
          end
        end
        if (have_cur) begin
          chk("bus_addr", bus_addr, cur.addr);
          chk("bus_sel", {28'd0, bus_sel}, {28'd0, cur.sel});
          chk("bus_we", {31'd0, bus_we}, {31'd0, cur.we});
          if (cur.chk_wdata) chk("bus_wdata", bus_wdata, cur.wdata);
        end
        req_n++;
      end else if (req_n > 0) begin
        if (have_cur) chk("bus_req_len", 32'(req_n), 32'(cur.len));
        req_n = 0;
        have_cur = 0;
      end
      if (load_valid || fault) begin
        if (resp_q.size() == 0) begin
          flag("unexpected_pulse");
        end else begin
          r = resp_q.pop_front();
          chk("pulse_kind", {30'd0, load_valid, fault}, {30'd0, ~r.is_fault, r.is_fault});
          chk("fault_cause", {30'd0, fault_cause}, {30'd0, r.cause});
          chk("pulse_load_data", load_data, r.data);
        end
      end
      if (stall) begin
        stall_n++;
      end else if (stall_n > 0) begin
        if (stall_q.size() == 0) begin
          flag("unexpected_stall");
        end else begin
          s = stall_q.pop_front();
          chk("stall_len", 32'(stall_n), 32'(s.len));
          chk("load_data_after", load_data, s.ld);
        end
        stall_n = 0;
      end
    end
  end

  // Reference model of one access, computed from the size/lane rules, then driven.
  task automatic issue(input bit is_load, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] sdata, input int delay, input logic [31:0] rdata,
                       input bit abort_rst);
    bit          legal, aligned, tmo;
    int          size, off;
    logic [1:0]  cause;
    logic [31:0] tmp, val, wd;
    longint      full, v;
    bus_exp_t    b;
    resp_t       r;
    stall_exp_t  s;
    if (is_load) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    else         legal = (f3 <= 3'd2);
    size    = 1 << f3[1:0];
    off     = int'(addr[1:0]);
    aligned = (off % size) == 0;
    cause   = !legal ? 2'd2 : (!aligned ? 2'd1 : 2'd0);
    tmo     = (cause == 2'd0) && (delay >= TMO);
    tmp  = rdata >> (8 * off);
    full = longint'(1) << (8 * size);
    v    = longint'(tmp) % full;
    if (!f3[2] && v >= full / 2) v = v - full;
    val = 32'(v);
    for (int i = 0; i < 4; i++) wd[8*i +: 8] = sdata[8*(i % size) +: 8];
    if (cause == 2'd0) begin
      b.addr = addr & 32'hFFFF_FFFC;
      b.sel = 4'(((1 << size) - 1) << off);
      b.we = !is_load;
      b.wdata = wd;
      b.chk_wdata = !is_load;
      b.len = abort_rst ? 2 : (tmo ? TMO : delay + 1);
      bus_q.push_back(b);
    end
    if (abort_rst) begin
      s.len = 3; s.ld = 32'd0;
    end else if (cause != 2'd0 || tmo) begin
      r.is_fault = 1'b1; r.cause = tmo ? 2'd3 : cause; r.data = 32'd0;
      resp_q.push_back(r);
      s.len = tmo ? TMO + 1 : 1; s.ld = 32'd0;
    end else if (is_load) begin
      r.is_fault = 1'b0; r.cause = 2'd0; r.data = val;
      resp_q.push_back(r);
      s.len = delay + 2; s.ld = val;
    end else begin
      s.len = delay + 2; s.ld = 32'd0;
    end
    stall_q.push_back(s);
    @(posedge clk); #1;
    plan_delay    = abort_rst ? -1 : delay;
    plan_rdata    = rdata;
    opcode        = is_load ? 7'b0000011 : 7'b0100011;
    funct3        = f3;
    read_address  = is_load ? addr : $urandom;
    write_address = is_load ? $urandom : addr;
    store_data    = sdata;
    if (abort_rst) begin
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      opcode = 7'b0110011;
    end else begin
      for (int c = 0; c <= 60; c++) begin
        @(negedge clk);
        if (!stall) break;
        if (c == 60) flag("stall_timeout");
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      case ($urandom_range(0, 5))
        0: opcode = 7'b0110011;
        1: opcode = 7'b0010011;
        2: opcode = 7'b1100011;
        3: opcode = 7'b1101111;
        4: opcode = 7'b0110111;
        default: opcode = 7'b0000000;
      endcase
      funct3 = 3'($urandom);
      read_address = $urandom;
      write_address = $urandom;
    end
  endtask

  initial begin : driver
    bit          ld;
    logic [2:0]  f3;
    logic [31:0] a;
    int          d;
    rst = 1'b1;
    opcode = 7'b0000000; funct3 = 3'd0;
    read_address = 32'd0; write_address = 32'd0; store_data = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);
    issue(1'b1, 3'b010, 32'h0000_1004, 32'h0, 0, 32'hDEAD_BEEF, 1'b0);
    idle(1);
    issue(1'b1, 3'b000, 32'h0000_1003, 32'h0, 0, 32'h8000_0000, 1'b0);
    issue(1'b1, 3'b100, 32'h0000_1003, 32'h0, 1, 32'h8000_0000, 1'b0);
    idle(1);
    issue(1'b0, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 3, 32'h0, 1'b0);
    issue(1'b1, 3'b010, 32'h0000_1002, 32'h0, 0, 32'h0, 1'b0);
    issue(1'b1, 3'b010, 32'h0000_3000, 32'h0, 100, 32'h0, 1'b0);
    issue(1'b1, 3'b011, 32'h0000_3001, 32'h0, 0, 32'h0, 1'b0);
    issue(1'b1, 3'b010, 32'h0000_4000, 32'h0, 0, 32'h0, 1'b1);
    idle(1);
    issue(1'b1, 3'b010, 32'h0000_5008, 32'h0, 1, 32'h0BAD_F00D, 1'b0);
    for (int n = 0; n < 150; n++) begin
      ld = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
      else if (ld) f3 = (($urandom_range(0, 1) == 0) ? 3'd0 : 3'd4) | 3'($urandom_range(0, 1)) | (($urandom_range(0, 4) == 0) ? 3'd2 : 3'd0);
      else f3 = 3'($urandom_range(0, 2));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'b01) a[0] = 1'b0;
        if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
      end
      d = ($urandom_range(0, 7) == 0) ? $urandom_range(TMO, TMO + 2) : $urandom_range(0, 3);
      issue(ld, f3, a, $urandom, d, $urandom, 1'b0);
      idle($urandom_range(0, 2));
    end
    idle(6);
    chk("bus_q_empty", 32'(bus_q.size()), 32'd0);
    chk("resp_q_empty", 32'(resp_q.size()), 32'd0);
    chk("stall_q_empty", 32'(stall_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
